proc_boot_ctrl: RTL and testbench
=================================

Name: proc_boot_ctrl

Overview:
- Sequencer wrapped around singleCycleProc: loads instruction memory from a streaming load port while holding the core in reset, releases the core, then counts run cycles until halt or timeout.
- Replaces the bench-driven reset/finish timing, so each program (beq, etc.) runs with a deterministic start and stop.
- Sits between the top level/bench and the core's rst input and imem write port.

Parameters:
- ADDR_W, 8, instruction memory word-address width (2^ADDR_W words).
- DATA_W, 32, instruction width.
- HALT_INSTR, 32'hFFFF_FFFF, instruction encoding treated as halt.
- MAX_CYCLES, 1000, run-cycle limit before forced timeout; must be >= 1.
- CNT_W, 16, cycle counter width; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load; ignored outside IDLE.
- load_valid  in  1  load word valid.
- load_data  in  DATA_W  load word.
- load_last  in  1  marks final word; qualified by load_valid.
- load_ready  out  1  controller accepts a load word.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  ADDR_W  instruction memory write address.
- imem_wdata  out  DATA_W  instruction memory write data.
- core_rst  out  1  active-high reset to singleCycleProc.
- core_instr  in  DATA_W  instruction the core is currently executing.
- cycle_count  out  CNT_W  core cycles executed in RUN.
- halted  out  1  program reached HALT_INSTR.
- timeout  out  1  MAX_CYCLES reached without halt.
- done  out  1  high in DONE state.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, core_rst=1, load_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cycle_count=0, halted=0, timeout=0, done=0.
- States: IDLE, LOAD, SETTLE, RUN, DONE.
- IDLE:
  - core_rst=1.
  - On start: go to LOAD, clear addr counter, cycle_count, halted, timeout.
- LOAD:
  - load_ready=1; core_rst=1.
  - Accept a word on load_valid & load_ready.
  - Registered write: imem_we=1, imem_addr=addr counter, imem_wdata=load_data in the cycle after acceptance, so the write lands 1 cycle after the handshake.
  - Addr counter increments per accepted word.
  - Accepted word with load_last=1, or accepted word at address 2^ADDR_W-1 (full; no wrap): go to SETTLE and drop load_ready. Further words are not accepted.
  - Zero-length loads are impossible; at least one word is always written.
- SETTLE:
  - Exactly 1 cycle, core_rst=1. The final imem write completes here, and the core samples reset with memory loaded.
  - Then go to RUN.
- RUN:
  - core_rst=0.
  - cycle_count increments each cycle, saturating at MAX_CYCLES.
  - If core_instr==HALT_INSTR: halted=1, go to DONE; the halt cycle is not counted.
  - Else if cycle_count==MAX_CYCLES-1 this cycle: count reaches MAX_CYCLES, timeout=1, go to DONE.
  - halted and timeout are mutually exclusive; halt wins if both conditions hold in the same cycle.
- DONE:
  - core_rst=1; done=1.
  - cycle_count, halted, timeout hold their values.
  - start returns to LOAD, clearing the counters.
- start is ignored in LOAD, SETTLE and RUN.
- Reset asserted mid-LOAD or mid-RUN aborts immediately to the IDLE reset values. Memory contents are left unspecified.

Optional Feature:
- Macro: PROC_BOOT_CTRL_STEP_EN.
- Defined:
  - Adds input step (1 bit) and input step_mode (1 bit).
  - In RUN with step_mode=1, the core advances only in the cycle step=1. In all other cycles core_rst stays 0 and a core clock-enable output core_ce (1 bit, added) is 0.
  - cycle_count and the halt check are evaluated only in cycles with core_ce=1.
- Undefined: no step/step_mode/core_ce ports; the core runs every RUN cycle.

Decomposition:
- Shared package proc_pkg holds:
  - the state enum (IDLE, LOAD, SETTLE, RUN, DONE);
  - DATA_W;
  - the HALT_INSTR default constant, reused by the assembler/bench.
- One natural sub-module: proc_cycle_counter (saturating counter with clear, enable, limit compare), shared with future multi-cycle bench variants.

Test Plan:
- Reset then start; stream 4 words 0x00000001..0x00000004, last on the 4th -> imem writes addr 0..3 with matching data, 1 cycle after each handshake; 1 SETTLE cycle; core_rst falls on the next cycle.
- load_valid toggling (valid on alternate cycles) -> only handshaken words written, addresses contiguous 0..N-1, no duplicate writes.
- RUN with core_instr = HALT_INSTR on the 7th RUN cycle -> halted=1, timeout=0, cycle_count=6, done=1, core_rst=1.
- MAX_CYCLES=10, no halt -> timeout=1 after exactly 10 RUN cycles, cycle_count=10, halted=0.
- ADDR_W=2, 6 words with no load_last -> 4 writes (addr 0..3), load_ready drops after the 4th handshake, no wrap to addr 0.
- rst low mid-RUN at cycle 3 -> all outputs return to reset values asynchronously; start after release reloads cleanly with cycle_count restarting from 0.

Source files
------------

// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared definitions for the processor boot sequencer: the
//               sequencer state encoding, the instruction width and the
//               default halt encoding reused by the assembler and benches.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    localparam int          PROC_DATA_W     = 32;
    localparam logic [31:0] PROC_HALT_INSTR = 32'hFFFF_FFFF;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/proc_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module      : proc_cycle_counter
// Description : Saturating up-counter with synchronous clear and enable.
//               Stops at LIMIT and flags the cycle in which the count sits
//               one below LIMIT so the owner can act on the final step.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_cycle_counter #(
    parameter int CNT_W = 16,
    parameter int LIMIT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             at_last
);

    localparam logic [CNT_W-1:0] C_LIMIT    = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] C_LIMIT_M1 = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: clear wins over enable; hold once the limit is reached
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != C_LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign at_last = (count_q == C_LIMIT_M1);

endmodule : proc_cycle_counter
`default_nettype wire

// File: rtl/proc_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : proc_boot_ctrl
// Description : Boot sequencer around the single-cycle core. Streams a
//               program into instruction memory with the core held in
//               reset, allows one settle cycle, releases the core and
//               counts run cycles until the halt encoding or a timeout.
//               Optional single-step support is built when the macro
//               PROC_BOOT_CTRL_STEP_EN is defined (adds step, step_mode
//               and core_ce ports).
// Revision    : 1.0 - initial release
// ============================================================================
module proc_boot_ctrl
    import proc_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = PROC_DATA_W,
    parameter logic [DATA_W-1:0] HALT_INSTR = DATA_W'(PROC_HALT_INSTR),
    parameter int                MAX_CYCLES = 1000,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    input  logic [DATA_W-1:0] core_instr,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              halted,
    output logic              timeout,
`ifdef PROC_BOOT_CTRL_STEP_EN
    input  logic              step,
    input  logic              step_mode,
    output logic              core_ce,
`endif
    output logic              done
);

    state_t state_d;
    state_t state_q;

    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_q;
    logic              imem_we_d;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_d;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [DATA_W-1:0] imem_wdata_d;
    logic [DATA_W-1:0] imem_wdata_q;
    logic              halted_d;
    logic              halted_q;
    logic              timeout_d;
    logic              timeout_q;

    logic              w_ce;
    logic              w_run_adv;
    logic              w_is_halt;
    logic              w_accept;
    logic              w_addr_full;
    logic              w_load_end;
    logic              w_start_ok;
    logic              w_cnt_en;
    logic              w_cnt_last;
    logic              w_to_hit;
    logic [CNT_W-1:0]  w_count;

`ifdef PROC_BOOT_CTRL_STEP_EN
    // Outside RUN the enable stays high so the core keeps clocking its reset
    always_comb begin
        w_ce = 1'b1;
        if ((state_q == ST_RUN) && step_mode) begin
            w_ce = step;
        end
    end
    assign core_ce = w_ce;
`else
    assign w_ce = 1'b1;
`endif

    // Handshake and run-phase qualifiers shared by the FSM and datapath
    assign w_run_adv   = (state_q == ST_RUN) && w_ce;
    assign w_is_halt   = (core_instr == HALT_INSTR);
    assign w_accept    = (state_q == ST_LOAD) && load_valid;
    assign w_addr_full = (addr_q == {ADDR_W{1'b1}});
    assign w_load_end  = w_accept && (load_last || w_addr_full);
    assign w_start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // The halt cycle itself is never counted
    assign w_cnt_en    = w_run_adv && !w_is_halt;
    assign w_to_hit    = w_cnt_en && w_cnt_last;

    proc_cycle_counter #(
        .CNT_W (CNT_W),
        .LIMIT (MAX_CYCLES)
    ) u_cycle_counter (
        .clk     (clk),
        .rst_n   (rst),
        .clr     (w_start_ok),
        .en      (w_cnt_en),
        .count   (w_count),
        .at_last (w_cnt_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; halt takes priority over timeout in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_load_end) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (w_run_adv && w_is_halt) begin
                    state_d = ST_DONE;
                end else if (w_to_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        core_rst   = (state_q != ST_RUN);
        load_ready = (state_q == ST_LOAD);
        done       = (state_q == ST_DONE);
    end

    // Load address, registered memory write and run-result flag updates
    always_comb begin
        addr_d       = addr_q;
        imem_we_d    = w_accept;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        halted_d     = halted_q;
        timeout_d    = timeout_q;

        if (w_start_ok) begin
            addr_d    = '0;
            halted_d  = 1'b0;
            timeout_d = 1'b0;
        end

        if (w_accept) begin
            imem_addr_d  = addr_q;
            imem_wdata_d = load_data;
            // A full memory ends the load, so the counter never wraps
            if (!w_addr_full) begin
                addr_d = addr_q + 1'b1;
            end
        end

        if (w_run_adv && w_is_halt) begin
            halted_d = 1'b1;
        end else if (w_to_hit) begin
            timeout_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            halted_q     <= halted_d;
            timeout_q    <= timeout_d;
        end
    end

    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign cycle_count = w_count;
    assign halted      = halted_q;
    assign timeout     = timeout_q;

endmodule : proc_boot_ctrl
`default_nettype wire

// File: tb/tb_proc_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_boot_ctrl
// Description : Self-checking bench for proc_boot_ctrl (ADDR_W=2,
//               MAX_CYCLES=10). Expected memory writes are queued at each
//               handshake and compared when the controller writes.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_proc_boot_ctrl;
    import proc_pkg::*;

    localparam int          ADDR_W     = 2;
    localparam int          DATA_W     = 32;
    localparam int          MAX_CYCLES = 10;
    localparam int          CNT_W      = 16;
    localparam logic [31:0] HALT       = PROC_HALT_INSTR;

    logic              clk        = 1'b0;
    logic              rst        = 1'b0;
    logic              start      = 1'b0;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data  = '0;
    logic              load_last  = 1'b0;
    logic [DATA_W-1:0] core_instr = '0;
    logic              load_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_rst;
    logic [CNT_W-1:0]  cycle_count;
    logic              halted;
    logic              timeout;
    logic              done;
`ifdef PROC_BOOT_CTRL_STEP_EN
    logic              step      = 1'b1;
    logic              step_mode = 1'b0;
    logic              core_ce;
`endif

    proc_boot_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .HALT_INSTR (HALT),
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_rst    (core_rst),
        .core_instr  (core_instr),
        .cycle_count (cycle_count),
        .halted      (halted),
        .timeout     (timeout),
`ifdef PROC_BOOT_CTRL_STEP_EN
        .step        (step),
        .step_mode   (step_mode),
        .core_ce     (core_ce),
`endif
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  cyc    = 0;
    int  n_chk  = 0;
    int  n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Write monitor: every imem write must match the oldest handshake, one cycle later
    always @(negedge clk) begin
        if (rst && imem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
                check("wr_data", imem_wdata, mon_e.data);
                check("wr_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_core_rst", core_rst, 1);
        check("rst_load_ready", load_ready, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_cycle_count", 32'(cycle_count), 0);
        check("rst_halted", halted, 0);
        check("rst_timeout", timeout, 0);
        check("rst_done", done, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("ld_ready", load_ready, 1);
        check("ld_core_rst", core_rst, 1);
        check("ld_cnt_clr", 32'(cycle_count), 0);
        check("ld_halt_clr", halted, 0);
        check("ld_to_clr", timeout, 0);
        check("ld_done", done, 0);
    endtask

    // Stream up to n words; returns at the first RUN-cycle negedge
    task automatic send_words(input int n, input bit use_last, input bit alt,
                              input logic [31:0] base, input int exp_acc);
        int idx   = 0;
        bit gap   = 1'b0;
        bit ended = 1'b0;
        for (int b = 0; b < 40; b++) begin
            @(negedge clk);
            if (!load_ready) begin
                ended = 1'b1;
                break;
            end
            load_valid = (idx < n) && !(alt && gap);
            load_data  = base + idx;
            load_last  = use_last && (idx == n - 1);
            gap        = ~gap;
            #1;
            if (load_valid && load_ready) begin
                exp_q.push_back('{addr: ADDR_W'(idx), data: base + idx, cyc: cyc + 1});
                idx++;
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("load_end_seen", ended, 1);
        check("words_accepted", idx, exp_acc);
        if (ended) begin
            check("settle_core_rst", core_rst, 1);
            check("settle_ready", load_ready, 0);
            @(negedge clk);
            check("run_core_rst", core_rst, 0);
        end
    endtask

    // Drive RUN cycles from cycle 1; abort_at returns early inside RUN
    task automatic run_prog(input int halt_at, input int start_at, input int abort_at,
                            input int exp_cnt, input bit exp_halt, input bit exp_to,
                            input int exp_runs);
        int k   = 1;
        bit fin = 1'b0;
        while (k <= 40) begin
            check("run_count", 32'(cycle_count), k - 1);
            if (k == abort_at) return;
            core_instr = (k == halt_at) ? HALT : (32'h0000_0013 + k);
            start      = (k == start_at);
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                fin = 1'b1;
                break;
            end
            k++;
        end
        core_instr = 32'h0000_0013;
        check("done_reached", fin, 1);
        check("run_cycles", k, exp_runs);
        check("done_core_rst", core_rst, 1);
        check("done_count", 32'(cycle_count), exp_cnt);
        check("done_halted", halted, exp_halt);
        check("done_timeout", timeout, exp_to);
        core_instr = HALT;
        repeat (2) @(negedge clk);
        check("hold_done", done, 1);
        check("hold_count", 32'(cycle_count), exp_cnt);
        check("hold_halted", halted, exp_halt);
        check("hold_timeout", timeout, exp_to);
        core_instr = 32'h0000_0013;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b1;

        // Four words with last on the fourth, halt on the 7th RUN cycle
        pulse_start();
        send_words(4, 1'b1, 1'b0, 32'h0000_0001, 4);
        run_prog(7, 0, 0, 6, 1'b1, 1'b0, 7);

        // Alternating valid, three words, no halt: timeout after 10 cycles
        pulse_start();
        send_words(3, 1'b1, 1'b1, 32'h0000_0100, 3);
        run_prog(0, 0, 0, MAX_CYCLES, 1'b0, 1'b1, MAX_CYCLES);

        // Six words without last into a 4-word memory; start ignored in RUN
        pulse_start();
        send_words(6, 1'b0, 1'b0, 32'h0000_0A00, 4);
        run_prog(4, 2, 0, 3, 1'b1, 1'b0, 4);

        // Asynchronous reset in RUN cycle 3, then a clean reload
        pulse_start();
        send_words(2, 1'b1, 1'b0, 32'h0000_0B00, 2);
        run_prog(0, 0, 3, 0, 1'b0, 1'b0, 0);
        #2 rst = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        rst = 1'b1;
        pulse_start();
        send_words(4, 1'b1, 1'b0, 32'h0000_0C00, 4);
        run_prog(2, 0, 0, 1, 1'b1, 1'b0, 2);

        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_proc_boot_ctrl
`default_nettype wire
